// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing : 640x480@60 raster timing with delayed sync/video_on, a       |
// |              frame_start strobe and a frame-counted blink flag.           |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module vga_timing #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int PIPE_DELAY   = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] counterX,
  output logic [9:0] counterY,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       blink
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] C_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] C_V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] C_HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] C_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] C_VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] C_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_FRAMES - 1);
  // Pipe word layout {hsync, vsync, video_on} at pin level; idle = deasserted.
  localparam logic [2:0] C_PIPE_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] frame_q, frame_d;
  logic       blink_q, blink_d;
  logic       line_end, frame_end;
  logic       hs_raw, vs_raw, vo_raw;
  logic [2:0] raw_lvl;
  logic [2:0] pipe_out;

  always_comb begin
    x_d       = x_q + 10'd1;
    y_d       = y_q;
    frame_d   = frame_q;
    blink_d   = blink_q;
    line_end  = (x_q == C_H_LAST);
    frame_end = line_end && (y_q == C_V_LAST);
    if (line_end) begin
      x_d = '0;
      y_d = (y_q == C_V_LAST) ? 10'd0 : (y_q + 10'd1);
    end
    if (frame_end) begin
      if (frame_q == C_BLINK_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
    end
  end

  assign hs_raw  = (x_q >= C_HS_START) && (x_q < C_HS_END);
  assign vs_raw  = (y_q >= C_VS_START) && (y_q < C_VS_END);
  assign vo_raw  = (x_q < C_H_VIS) && (y_q < C_V_VIS);
  assign raw_lvl = {~(hs_raw ^ SYNC_POL), ~(vs_raw ^ SYNC_POL), vo_raw};

  // Delay matches the framebuffer's text_ram + glyph_rom read latency.
  if (PIPE_DELAY == 0) begin : g_direct
    assign pipe_out = raw_lvl;
  end else begin : g_pipe
    logic [2:0] pipe_q [PIPE_DELAY];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= C_PIPE_IDLE;
      end else begin
        pipe_q[0] <= raw_lvl;
        for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign pipe_out = pipe_q[PIPE_DELAY-1];
  end

  assign counterX    = x_q;
  assign counterY    = y_q;
  assign hsync       = pipe_out[2];
  assign vsync       = pipe_out[1];
  assign video_on    = pipe_out[0];
  assign frame_start = (x_q == 10'd0) && (y_q == 10'd0) && !rst;
  assign blink       = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing : directed bench for vga_timing (default, zero-delay and    |
// |                 small-raster instances sharing one clock and reset).      |
// | Revision      : 1.0  initial release                                       |
// +----------------------------------------------------------------------------+
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: default timing, PIPE_DELAY=2
  logic [9:0] x_a, y_a;
  logic hs_a, vs_a, vo_a, fs_a, bl_a;
  // b: default timing, PIPE_DELAY=0
  logic [9:0] x_b, y_b;
  logic hs_b, vs_b, vo_b, fs_b, bl_b;
  // c: 16x8 raster (frame = 128 cycles), PIPE_DELAY=2, BLINK_FRAMES=2
  logic [9:0] x_c, y_c;
  logic hs_c, vs_c, vo_c, fs_c, bl_c;

  vga_timing u_a (
    .clk(clk), .rst(rst), .counterX(x_a), .counterY(y_a), .hsync(hs_a),
    .vsync(vs_a), .video_on(vo_a), .frame_start(fs_a), .blink(bl_a)
  );

  vga_timing #(.PIPE_DELAY(0)) u_b (
    .clk(clk), .rst(rst), .counterX(x_b), .counterY(y_b), .hsync(hs_b),
    .vsync(vs_b), .video_on(vo_b), .frame_start(fs_b), .blink(bl_b)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .PIPE_DELAY(2), .BLINK_FRAMES(2)
  ) u_c (
    .clk(clk), .rst(rst), .counterX(x_c), .counterY(y_c), .hsync(hs_c),
    .vsync(vs_c), .video_on(vo_c), .frame_start(fs_c), .blink(bl_c)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cur_k    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s k=%0d got=%0d expected=%0d", tag, cur_k, got, exp);
  endtask

  // k = cycles since reset release (k=0 is the cycle counters read (0,0)).
  task automatic check_all(input int k);
    int kk, xa, ya, xc, yc, nwr;
    cur_k = k;
    kk = k - 2;
    // instance a
    chk("a_x", 32'(x_a), 32'(k % 800));
    chk("a_y", 32'(y_a), 32'(k / 800));
    chk("a_fs", 32'(fs_a), 32'(k == 0));
    chk("a_blink", 32'(bl_a), 32'd0);
    chk("a_vsync", 32'(vs_a), 32'd1);
    if (k < 2) begin
      chk("a_hsync", 32'(hs_a), 32'd1);
      chk("a_vo", 32'(vo_a), 32'd0);
    end else begin
      xa = kk % 800;
      ya = kk / 800;
      chk("a_hsync", 32'(hs_a), 32'(!(xa >= 656 && xa <= 751)));
      chk("a_vo", 32'(vo_a), 32'(xa < 640 && ya < 480));
    end
    // instance b: no delay
    chk("b_x", 32'(x_b), 32'(k % 800));
    chk("b_hsync", 32'(hs_b), 32'(!((k % 800) >= 656 && (k % 800) <= 751)));
    chk("b_vo", 32'(vo_b), 32'((k % 800) < 640));
    chk("b_fs", 32'(fs_b), 32'(k == 0));
    // instance c: blink toggles on every 2nd frame wrap
    nwr = k / 128;
    chk("c_x", 32'(x_c), 32'(k % 16));
    chk("c_y", 32'(y_c), 32'((k / 16) % 8));
    chk("c_fs", 32'(fs_c), 32'((k % 128) == 0));
    chk("c_blink", 32'(bl_c), 32'((nwr / 2) % 2));
    if (k < 2) begin
      chk("c_hsync", 32'(hs_c), 32'd1);
      chk("c_vsync", 32'(vs_c), 32'd1);
      chk("c_vo", 32'(vo_c), 32'd0);
    end else begin
      xc = kk % 16;
      yc = (kk / 16) % 8;
      chk("c_hsync", 32'(hs_c), 32'(!(xc >= 10 && xc <= 12)));
      chk("c_vsync", 32'(vs_c), 32'(yc != 5));
      chk("c_vo", 32'(vo_c), 32'(xc < 8 && yc < 4));
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k <= 1900; k++) begin
      @(negedge clk);
      check_all(k);
    end
    // Mid-frame reset: a at (300,2), c at frame 14 with blink high.
    chk("a_mid_x", 32'(x_a), 32'd300);
    chk("c_mid_blink", 32'(bl_c), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    cur_k = -1;
    chk("rst_fs", 32'(fs_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      check_all(k);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
